// File: rtl/pong_input_ctrl.sv
// Button/switch front end for the pong core: synchronise, debounce, latch once per frame.
// Optional attract-mode autopilot is compiled in with `define PONG_INPUT_DEMO_MODE_EN.
module pong_input_ctrl #(
  parameter int DEBOUNCE_CYCLES  = 250000,
  parameter int IDLE_FRAMES      = 1800,
  parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] btn_raw,
  input  logic [1:0] sw_raw,
  input  logic       vsync,
  output logic [3:0] btn_out,
  output logic [1:0] sw_out,
  output logic       frame_tick,
  output logic       demo_active
);

  localparam int NB = 6;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic VS_IDLE = VSYNC_ACTIVE_LOW;

  // Buttons in bits [3:0], switches in [5:4] so one debouncer bank serves both.
  logic [NB-1:0] raw_bits;
  logic [NB-1:0] sync1;
  logic [NB-1:0] sync2;
  logic [NB-1:0] deb;
  logic [CW-1:0] cnt [NB];

  logic [3:0] btn_deb;
  logic [1:0] sw_deb;
  logic       any_btn;

  logic vsync_q;
  logic vs_act;
  logic vs_act_q;

  logic [3:0] btn_nxt;

  assign raw_bits = {sw_raw, btn_raw};
  assign btn_deb  = deb[3:0];
  assign sw_deb   = deb[5:4];
  assign any_btn  = |btn_deb;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_bits;
      sync2 <= sync1;
    end
  end

  // Each bit flips only after its synchronised input has disagreed for DEBOUNCE_CYCLES edges.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      deb <= '0;
      for (int i = 0; i < NB; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= ~deb[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // vsync is already in this clock domain, so a single delayed copy is enough for edge detect.
  assign vs_act   = VSYNC_ACTIVE_LOW ? ~vsync   : vsync;
  assign vs_act_q = VSYNC_ACTIVE_LOW ? ~vsync_q : vsync_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vsync_q    <= VS_IDLE;
      frame_tick <= 1'b0;
    end else begin
      vsync_q    <= vsync;
      frame_tick <= vs_act & ~vs_act_q;
    end
  end

`ifdef PONG_INPUT_DEMO_MODE_EN
  typedef enum logic {
    PLAY = 1'b0,
    DEMO = 1'b1
  } state_t;

  localparam int IW = $clog2(IDLE_FRAMES + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_FRAMES);

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] idle_cnt;
  logic [IW-1:0] idle_nxt;
  logic [7:0]    lfsr;
  logic [7:0]    lfsr_nxt;
  logic          lfsr_fb;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= PLAY;
      idle_cnt <= '0;
      lfsr     <= 8'hA5;
    end else begin
      state    <= state_nxt;
      idle_cnt <= idle_nxt;
      lfsr     <= lfsr_nxt;
    end
  end

  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  always_comb begin
    state_nxt = state;
    idle_nxt  = idle_cnt;
    lfsr_nxt  = lfsr;
    if (any_btn) begin
      idle_nxt = '0;
    end else if (frame_tick && (state == PLAY) && (idle_cnt != IDLE_MAX)) begin
      idle_nxt = idle_cnt + IW'(1);
    end
    // A press on the very tick that would start the demo keeps the player in control.
    case (state)
      PLAY: begin
        if (frame_tick && !any_btn && (idle_nxt == IDLE_MAX)) begin
          state_nxt = DEMO;
        end
      end
      DEMO: begin
        if (any_btn) begin
          state_nxt = PLAY;
        end
        if (frame_tick) begin
          lfsr_nxt = {lfsr[6:0], lfsr_fb};
        end
      end
      default: state_nxt = PLAY;
    endcase
  end

  // Autopilot drives only U or D, decoded from the freshly advanced LFSR value.
  always_comb begin
    btn_nxt     = btn_deb;
    demo_active = (state == DEMO);
    if (state == DEMO) begin
      btn_nxt = {~lfsr_nxt[0] & lfsr_nxt[1], 2'b00, lfsr_nxt[0]};
    end
  end
`else
  assign btn_nxt     = btn_deb;
  assign demo_active = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_out <= '0;
      sw_out  <= '0;
    end else if (frame_tick) begin
      btn_out <= btn_nxt;
      sw_out  <= sw_deb;
    end
  end

endmodule

// File: doc/pong_input_ctrl.md
PONG_INPUT_CTRL -- requirements
Module: pong_input_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000: consecutive stable cycles needed before a debounced value changes (5 ms at 50 MHz).
REQ-002 Parameter IDLE_FRAMES, default 1800: frames with no button held before demo entry (30 s at 60 Hz).
REQ-003 Parameter VSYNC_ACTIVE_LOW, default 1: polarity of the vsync input.
REQ-004 Port: clock, input, 1, single clock; the same clock that drives the game core.
REQ-005 Port: reset, input, 1, asynchronous, active-high.
REQ-006 Port: btn_raw, input, 4, raw buttons {D,R,L,U} (bit0=U, bit1=L, bit2=R, bit3=D).
REQ-007 Port: sw_raw, input, 2, raw switches.
REQ-008 Port: vsync, input, 1, game VSYNC; synchronous to clock.
REQ-009 Port: btn_out, output, 4, frame-stable buttons for the game, same bit order as btn_raw.
REQ-010 Port: sw_out, output, 2, frame-stable switches.
REQ-011 Port: frame_tick, output, 1, one-cycle pulse at each vsync assertion edge.
REQ-012 Port: demo_active, output, 1, high while the state is DEMO.

Function
REQ-013 Each btn_raw and sw_raw bit SHALL pass through a 2-flop synchronizer before debouncing.
REQ-014 Each bit SHALL have its own counter of width clog2(DEBOUNCE_CYCLES+1):
- counter clears whenever the synchronized bit equals the debounced bit;
- otherwise the counter increments;
- when it reaches DEBOUNCE_CYCLES-1 while still differing, the debounced bit flips on that edge and the counter clears.
REQ-015 frame_tick SHALL be high for exactly one cycle on the edge where vsync goes inactive->active, detected with one registered copy of vsync (no synchronizer).
REQ-016 btn_out and sw_out SHALL update only on the clock edge where frame_tick is high; at all other times they hold.
REQ-017 sw_out SHALL always load the debounced switches, in both states.
REQ-018 The FSM SHALL have two states, PLAY and DEMO.
REQ-019 In PLAY, on each frame_tick btn_out SHALL load the debounced buttons.
REQ-020 Idle counter, width clog2(IDLE_FRAMES+1), saturating:
- clears in any cycle where any debounced button is 1;
- otherwise increments on each frame_tick while in PLAY.
REQ-021 PLAY->DEMO SHALL occur on the frame_tick edge where the idle count reaches IDLE_FRAMES, provided no debounced button is 1 in that cycle; if a button is 1, the state stays PLAY (press wins).
REQ-022 In DEMO, an 8-bit Fibonacci LFSR (taps 8,6,5,4) SHALL advance once per frame_tick.
REQ-023 In DEMO, btn_out on each frame_tick SHALL load {~l[0]&l[1], 1'b0, 1'b0, l[0]}, where l is the LFSR value after that advance; U and D are never both 1.
REQ-024 DEMO->PLAY SHALL occur on the first cycle any debounced button is 1; the idle counter clears.
REQ-025 On the next frame_tick after DEMO->PLAY, btn_out SHALL load real debounced buttons.
REQ-026 demo_active SHALL equal (state==DEMO), registered.
REQ-027 The LFSR SHALL hold its value in PLAY and never reach the all-zero state.

Reset
REQ-028 While reset is high, all of the following SHALL hold immediately, independent of clock:
- btn_out=0, sw_out=0, frame_tick=0, demo_active=0, state=PLAY;
- synchronizers, debounced bits, debounce counters and idle counter = 0;
- LFSR = 8'hA5;
- registered vsync = inactive level (1 when VSYNC_ACTIVE_LOW=1), so no tick fires on the first cycle after reset.
REQ-029 Reset asserted mid-debounce or mid-DEMO SHALL discard all progress; operation restarts in PLAY.

Configuration
REQ-030 Macro PONG_INPUT_DEMO_MODE_EN defined: the idle counter, LFSR and DEMO state (REQ-020 to REQ-027) are compiled in.
REQ-031 Macro PONG_INPUT_DEMO_MODE_EN undefined:
- idle counter, LFSR and DEMO state are absent;
- the FSM is permanently PLAY and demo_active is tied 0;
- all other behaviour is identical.

Verification (DEBOUNCE_CYCLES=4, IDLE_FRAMES=3, vsync active-low, macro defined)
REQ-032 btn_raw[0] high for 3 cycles then low -> debounced U never rises; btn_out stays 4'b0000 across the next frame_tick.
REQ-033 btn_raw=4'b0001 held 10 cycles, then vsync 1->0 -> frame_tick pulses exactly 1 cycle; btn_out=4'b0001 on that edge and unchanged until the next tick.
REQ-034 Buttons released, 3 frame_ticks -> demo_active=1 after the 3rd tick; btn_out follows REQ-023 from LFSR seed A5 on the following ticks and never equals 4'b1001.
REQ-035 In DEMO, btn_raw=4'b0100 held 6 cycles -> demo_active falls when debounced R rises; next frame_tick gives btn_out=4'b0100.
REQ-036 Idle count=2, debounced press in the same cycle as the 3rd frame_tick -> state stays PLAY; idle counter = 0.
REQ-037 reset pulsed while in DEMO with btn_out=4'b0001 -> all outputs 0 and demo_active=0 during reset, before any clock edge; no frame_tick on the first post-reset cycle with vsync=1.
